// File: rtl/vga_timing_gen_if.sv
// VGA timing output bundle: pixel position, syncs, blanking and strobes.
// The generator drives it through the master modport; consumers use slave.
interface vga_timing_gen_if;
    logic signed [31:0] pixel_column;
    logic signed [31:0] pixel_row;
    logic               horiz_sync;
    logic               vert_sync;
    logic               video_on;
    logic               pix_en;
    logic               frame_start;

    modport master (
        output pixel_column,
        output pixel_row,
        output horiz_sync,
        output vert_sync,
        output video_on,
        output pix_en,
        output frame_start
    );

    modport slave (
        input pixel_column,
        input pixel_row,
        input horiz_sync,
        input vert_sync,
        input video_on,
        input pix_en,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A clock divider produces one "advance" edge
// every CLK_DIV clocks. On that edge the column/row counters step, and every
// output is re-registered from the new position. Syncs, blanking and strobes
// therefore always describe the position currently on the outputs.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One spare count of headroom so that every boundary constant fits.
    // This holds even when a porch is zero and a sync edge lands exactly on H_TOTAL.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_W   = $clog2(H_TOTAL + 1);
    localparam int V_W   = $clog2(V_TOTAL + 1);

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_END    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   H_SYNC_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST       = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_END    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   V_SYNC_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   col_q, col_d;
    logic [V_W-1:0]   row_q, row_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             video_on_q, video_on_d;
    logic             pix_en_q, pix_en_d;
    logic             frame_start_q, frame_start_d;
    logic             advance;

    // Divider and raster counters: step column, carry into row, wrap the frame.
    always_comb begin
        advance = (div_q == DIV_LAST);
        div_d   = advance ? '0 : div_q + 1'b1;
        col_d   = col_q;
        row_d   = row_q;
        if (advance) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Decode the position being loaded, so decoded outputs match the counters.
    always_comb begin
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        video_on_d    = video_on_q;
        pix_en_d      = 1'b0;
        frame_start_d = 1'b0;
        if (advance) begin
            video_on_d    = (col_d < H_ACT_END) && (row_d < V_ACT_END);
            h_sync_d      = ((col_d >= H_SYNC_START) && (col_d < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            v_sync_d      = ((row_d >= V_SYNC_START) && (row_d < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            pix_en_d      = 1'b1;
            frame_start_d = (col_d == '0) && (row_d == '0);
        end
    end

    // State and output registers; reset parks everything at (0,0), blanked, syncs idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            h_sync_q      <= SYNC_OFF;
            v_sync_q      <= SYNC_OFF;
            video_on_q    <= 1'b0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_column = 32'(col_q);
    assign vga.pixel_row    = 32'(row_q);
    assign vga.horiz_sync   = h_sync_q;
    assign vga.vert_sync    = v_sync_q;
    assign vga.video_on     = video_on_q;
    assign vga.pix_en       = pix_en_q;
    assign vga.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share one clock and reset:
// - defaults;
// - a tiny raster with CLK_DIV=2, so that whole frames fit in a short run;
// - a tiny raster with CLK_DIV=1 and high-true syncs.
// Expected outputs come from an arithmetic model that is indexed by the number of clocks since the last reset edge.
module tb_vga_timing_gen;

    localparam int S_DIV = 2;
    localparam int S_HA = 8,  S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int S_FRAME_CLK = S_DIV * (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);
    localparam int F_HA = 10, F_HFP = 2, F_HS = 4, F_HBP = 3;
    localparam int F_VA = 4,  F_VFP = 2, F_VS = 1, F_VBP = 2;

    typedef struct packed {
        logic signed [31:0] col;
        logic signed [31:0] row;
        logic               hs;
        logic               vs;
        logic               von;
        logic               pe;
        logic               fs;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   k           = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if def_if ();
    vga_timing_gen_if small_if ();
    vga_timing_gen_if fast_if ();

    vga_timing_gen u_def (
        .clk   (clk),
        .reset (reset),
        .vga   (def_if)
    );

    vga_timing_gen #(
        .CLK_DIV(S_DIV), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_ACTIVE(0)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .vga   (small_if)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(F_HA), .H_FP(F_HFP), .H_SYNC(F_HS), .H_BP(F_HBP),
        .V_ACTIVE(F_VA), .V_FP(F_VFP), .V_SYNC(F_VS), .V_BP(F_VBP), .SYNC_ACTIVE(1)
    ) u_fast (
        .clk   (clk),
        .reset (reset),
        .vga   (fast_if)
    );

    // Reference: after k clocks out of reset, floor(k/div) pixels have elapsed.
    function automatic obs_t model(input int div, input int ha, input int hfp, input int hs,
                                   input int hbp, input int va, input int vfp, input int vs,
                                   input int vbp, input int sa, input int kk);
        obs_t o;
        int ht, vt, adv, p, c, r;
        ht    = ha + hfp + hs + hbp;
        vt    = va + vfp + vs + vbp;
        adv   = kk / div;
        o.col = 0;
        o.row = 0;
        o.hs  = (sa == 0);
        o.vs  = (sa == 0);
        o.von = 1'b0;
        o.pe  = 1'b0;
        o.fs  = 1'b0;
        if (adv > 0) begin
            p     = adv % (ht * vt);
            c     = p % ht;
            r     = p / ht;
            o.col = c;
            o.row = r;
            o.von = (c < ha) && (r < va);
            o.hs  = ((c >= ha + hfp) && (c < ha + hfp + hs)) ? (sa != 0) : (sa == 0);
            o.vs  = ((r >= va + vfp) && (r < va + vfp + vs)) ? (sa != 0) : (sa == 0);
            o.pe  = (kk % div) == 0;
            o.fs  = o.pe && (p == 0);
        end
        return o;
    endfunction

    function automatic obs_t model_def(input int kk);
        return model(4, 640, 16, 96, 48, 480, 10, 2, 33, 0, kk);
    endfunction

    function automatic obs_t model_small(input int kk);
        return model(S_DIV, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 0, kk);
    endfunction

    function automatic obs_t model_fast(input int kk);
        return model(1, F_HA, F_HFP, F_HS, F_HBP, F_VA, F_VFP, F_VS, F_VBP, 1, kk);
    endfunction

    function automatic obs_t obs_def();
        return {def_if.pixel_column, def_if.pixel_row, def_if.horiz_sync, def_if.vert_sync,
                def_if.video_on, def_if.pix_en, def_if.frame_start};
    endfunction

    function automatic obs_t obs_small();
        return {small_if.pixel_column, small_if.pixel_row, small_if.horiz_sync, small_if.vert_sync,
                small_if.video_on, small_if.pix_en, small_if.frame_start};
    endfunction

    function automatic obs_t obs_fast();
        return {fast_if.pixel_column, fast_if.pixel_row, fast_if.horiz_sync, fast_if.vert_sync,
                fast_if.video_on, fast_if.pix_en, fast_if.frame_start};
    endfunction

    // One clock with the given reset level. It returns at the falling edge, where outputs are stable.
    task automatic tick(input logic rst);
        reset = rst;
        @(posedge clk);
        if (rst) k = 0;
        else     k++;
        @(negedge clk);
    endtask

    // Hold reset for a random number of clocks; every instance must sit at its reset values.
    task automatic test_reset();
        int n;
        n = $urandom_range(3, 7);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            vectors++;
            if (obs_def() !== model_def(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_def k=%0d got %h want %h", k, obs_def(), model_def(k));
            end
            vectors++;
            if (obs_small() !== model_small(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_small k=%0d got %h want %h", k, obs_small(), model_small(k));
            end
            vectors++;
            if (obs_fast() !== model_fast(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_fast k=%0d got %h want %h", k, obs_fast(), model_fast(k));
            end
        end
    endtask

    // At defaults, the first advance is the 4th clock and lands on (1,0) with video on.
    task automatic test_release();
        for (int i = 0; i < 4; i++) tick(1'b0);
        vectors++;
        if ({def_if.pixel_column, def_if.pixel_row, def_if.video_on, def_if.pix_en, def_if.frame_start}
            !== {32'sd1, 32'sd0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL first_advance col=%0d row=%0d von=%b pe=%b fs=%b want 1 0 1 1 0",
                     def_if.pixel_column, def_if.pixel_row, def_if.video_on, def_if.pix_en,
                     def_if.frame_start);
        end
        tick(1'b0);
        vectors++;
        if (def_if.pix_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pix_en_width got %b want 0", def_if.pix_en);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            vectors++;
            if (obs_def() !== model_def(k)) begin
                miscompares++;
                $display("[TB] FAIL release_def k=%0d got %h want %h", k, obs_def(), model_def(k));
            end
        end
    endtask

    // Run the default raster across two line wraps, checking the model and invariants each clock.
    task automatic test_line_timing();
        logic inv_ok;
        for (int i = 0; i < 7000; i++) begin
            tick(1'b0);
            vectors++;
            if (obs_def() !== model_def(k)) begin
                miscompares++;
                $display("[TB] FAIL line_def k=%0d got %h want %h", k, obs_def(), model_def(k));
            end
            inv_ok = !def_if.video_on ||
                     ((def_if.pixel_column < 640) && (def_if.pixel_row < 480) && def_if.horiz_sync);
            vectors++;
            if (inv_ok !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL invariant k=%0d got %b want 1", k, inv_ok);
            end
        end
    endtask

    // Small raster over three frames; frame_start must fire once per frame period.
    task automatic test_frame_wrap();
        int fs_count;
        int n;
        tick(1'b1);
        tick(1'b1);
        fs_count = 0;
        n        = 3 * S_FRAME_CLK + 20;
        for (int i = 0; i < n; i++) begin
            tick(1'b0);
            if (small_if.frame_start === 1'b1) fs_count++;
            vectors++;
            if (obs_small() !== model_small(k)) begin
                miscompares++;
                $display("[TB] FAIL frame_small k=%0d got %h want %h", k, obs_small(), model_small(k));
            end
        end
        vectors++;
        if (fs_count !== n / S_FRAME_CLK) begin
            miscompares++;
            $display("[TB] FAIL frame_count got %0d want %0d", fs_count, n / S_FRAME_CLK);
        end
    endtask

    // CLK_DIV=1 with high-true syncs: every clock advances, and pix_en never drops.
    task automatic test_fast_mode();
        int n;
        n = $urandom_range(300, 600);
        for (int i = 0; i < n; i++) begin
            tick(1'b0);
            vectors++;
            if (obs_fast() !== model_fast(k)) begin
                miscompares++;
                $display("[TB] FAIL fast k=%0d got %h want %h", k, obs_fast(), model_fast(k));
            end
            vectors++;
            if (fast_if.pix_en !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fast_pix_en k=%0d got %b want 1", k, fast_if.pix_en);
            end
        end
    endtask

    // Reset mid-frame at small-raster (5,4): immediate reset values, then a clean restart.
    task automatic test_mid_reset();
        tick(1'b1);
        for (int i = 0; i < S_DIV * (4 * (S_HA + S_HFP + S_HS + S_HBP) + 5); i++) tick(1'b0);
        vectors++;
        if ({small_if.pixel_column, small_if.pixel_row} !== {32'sd5, 32'sd4}) begin
            miscompares++;
            $display("[TB] FAIL mid_position got (%0d,%0d) want (5,4)",
                     small_if.pixel_column, small_if.pixel_row);
        end
        tick(1'b1);
        vectors++;
        if (obs_small() !== {32'sd0, 32'sd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_small got %h want all-reset", obs_small());
        end
        vectors++;
        if (obs_fast() !== {32'sd0, 32'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_fast got %h want all-reset", obs_fast());
        end
        for (int i = 0; i < S_FRAME_CLK + 20; i++) begin
            tick(1'b0);
            vectors++;
            if (obs_small() !== model_small(k)) begin
                miscompares++;
                $display("[TB] FAIL restart_small k=%0d got %h want %h", k, obs_small(), model_small(k));
            end
        end
    endtask

    // Random run lengths broken by random short resets, checking all instances.
    task automatic test_random_reset();
        int run_len;
        int rst_len;
        for (int it = 0; it < 6; it++) begin
            run_len = $urandom_range(20, 500);
            rst_len = $urandom_range(1, 3);
            for (int i = 0; i < run_len + rst_len; i++) begin
                tick(i >= run_len);
                vectors++;
                if (obs_def() !== model_def(k)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_def k=%0d got %h want %h", k, obs_def(), model_def(k));
                end
                vectors++;
                if (obs_small() !== model_small(k)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_small k=%0d got %h want %h", k, obs_small(), model_small(k));
                end
                vectors++;
                if (obs_fast() !== model_fast(k)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_fast k=%0d got %h want %h", k, obs_fast(), model_fast(k));
                end
            end
        end
    endtask

    // Run the scenarios in order and print the summary.
    initial begin
        test_reset();
        test_release();
        test_line_timing();
        test_frame_wrap();
        test_fast_mode();
        test_mid_reset();
        test_random_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- CLK_DIV, 4, clk cycles per pixel; legal values are 1 or more.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal active, front porch, sync and back porch, in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical active, front porch, sync and back porch, in lines.
- SYNC_ACTIVE, 0, sync pulse polarity (0 = active-low).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single system clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- pixel_column, out, 32 signed, current horizontal count 0..H_TOTAL-1.
- pixel_row, out, 32 signed, current vertical count 0..V_TOTAL-1.
- horiz_sync, out, 1, horizontal sync.
- vert_sync, out, 1, vertical sync.
- video_on, out, 1, high when the current pixel is inside the active area.
- pix_en, out, 1, one-clk strobe following each pixel advance.
- frame_start, out, 1, one-clk strobe when the counters wrap to (0,0).

REQ-003 The block SHALL use one clock domain, with reset synchronous and active-high exactly as named above.

Function
REQ-004 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).

REQ-005 An internal divider SHALL count 0..CLK_DIV-1 and wrap, incrementing every clk.

REQ-006 The pixel counters SHALL advance only on an edge where the divider equals CLK_DIV-1 (an "advance edge"). When CLK_DIV=1, every edge is an advance edge.

REQ-007 On an advance edge, pixel_column SHALL increment. At H_TOTAL-1 it SHALL wrap to 0 and pixel_row SHALL increment in the same edge.

REQ-008 When pixel_row is V_TOTAL-1 and pixel_column wraps, pixel_row SHALL wrap to 0 in the same edge.

REQ-009 All outputs SHALL be registered and updated on the advance edge, so that syncs, video_on and strobes always describe the pixel_column/pixel_row pair currently presented. There SHALL be no skew between outputs.

REQ-010 video_on SHALL be 1 if and only if pixel_column < H_ACTIVE and pixel_row < V_ACTIVE.

REQ-011 horiz_sync SHALL equal SYNC_ACTIVE if and only if H_ACTIVE+H_FP <= pixel_column < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults); otherwise it SHALL equal the inverse of SYNC_ACTIVE.

REQ-012 vert_sync SHALL equal SYNC_ACTIVE if and only if V_ACTIVE+V_FP <= pixel_row < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults), regardless of pixel_column.

REQ-013 pix_en SHALL be 1 for exactly the one clk following each advance edge and 0 otherwise. When CLK_DIV=1, pix_en SHALL be constantly 1 after the first edge out of reset.

REQ-014 frame_start SHALL be 1 for exactly the one clk following an advance edge that wraps the counters to (0,0), coincident with pix_en. It SHALL NOT assert on reset release.

REQ-015 pixel_column and pixel_row SHALL never exceed H_TOTAL-1 and V_TOTAL-1 respectively, and SHALL never go negative.

Reset
REQ-016 While reset=1 at a clk edge, the block SHALL drive:
- divider = 0;
- pixel_column = 0 and pixel_row = 0;
- horiz_sync and vert_sync = inverse of SYNC_ACTIVE;
- video_on = 0, pix_en = 0, frame_start = 0.

REQ-017 Reset asserted mid-frame SHALL take effect on that edge, with no partial line or frame completion.

REQ-018 The first advance edge after reset release SHALL be the CLK_DIV-th edge and SHALL move the counters to (1,0). Pixel (0,0) of the first frame is therefore blanked (video_on=0); this is intended behaviour.

Verification
REQ-019 Reset release, defaults: after 4 clk, pixel_column=1, pixel_row=0, video_on=1, and pix_en is high for 1 clk. pix_en then repeats with a period of 4 clk.

REQ-020 Line timing: horiz_sync=0 for pixel_column 656..751 and returns to 1 at 752. video_on=0 for columns 640..799. Column 799 -> 0 with pixel_row+1 on the same advance edge.

REQ-021 Frame wrap: (799,524) -> (0,0) with frame_start high for exactly 1 clk. frame_start occurs once per 420000 pix_en strobes (1680000 clk). vert_sync=0 only on rows 490..491.

REQ-022 Reset mid-frame at (300,200): on the next edge all outputs take their reset values. Counting restarts per REQ-018, and no frame_start is issued.

REQ-023 CLK_DIV=1, SYNC_ACTIVE=1: pix_en is constantly 1, the counters advance every clk, the sync pulses are high-true, and the frame period is 420000 clk.

REQ-024 Invariant, checked every cycle: video_on implies pixel_column<640 and pixel_row<480; horiz_sync and video_on are never both active.
